fetch_flush_controller: RTL

//  Sequences every fetch-pipeline flush and restart. Arbitrates the FlushReason sources and latches one redirect PC.

---
 rtl/fetch_flush_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_flush_controller.sv
// Sequences fetch-pipeline flushes: arbitrates redirect sources, latches the restart PC,
// drives the ITLB/ICache handshakes the reason needs, then restarts fetch at the latched PC.
module fetch_flush_controller #(
  parameter int unsigned          PC_WIDTH        = 32,
  parameter logic [PC_WIDTH-1:0]  INITIAL_PC      = 32'h8000_0000,
  parameter int unsigned          MAX_WAIT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trapReq_i,
  input  logic [PC_WIDTH-1:0] trapVector_i,
  input  logic                branchReq_i,
  input  logic [PC_WIDTH-1:0] branchTarget_i,
  input  logic                invalidateReq_i,
  input  logic [PC_WIDTH-1:0] invalidatePc_i,
  input  logic                fetchMissReq_i,
  input  logic [2:0]          fetchMissReason_i,
  input  logic [PC_WIDTH-1:0] fetchMissPc_i,
  input  logic                itlbRefillDone_i,
  input  logic                icacheRefillDone_i,
  input  logic                icacheInvalidateDone_i,
  input  logic                insnBufferFull_i,
  output logic                flush_o,
  output logic [2:0]          flushReason_o,
  output logic [PC_WIDTH-1:0] redirectPc_o,
  output logic                restartValid_o,
  output logic                fetchEnable_o,
  output logic                itlbRefillReq_o,
  output logic                icacheRefillReq_o,
  output logic                icacheInvalidateReq_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned     CNT_W   = $clog2(MAX_WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] R_NONE   = 3'd0;
  localparam logic [2:0] R_BRANCH = 3'd1;
  localparam logic [2:0] R_TRAP   = 3'd2;
  localparam logic [2:0] R_INVAL  = 3'd3;
  localparam logic [2:0] R_ITLB   = 3'd4;
  localparam logic [2:0] R_ICACHE = 3'd5;
  localparam logic [2:0] R_IBFULL = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT, S_RESTART} state_e;

  state_e                state_q, state_d;
  logic [2:0]            reason_q, reason_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic                  hi_req, miss_ok, done_match;
  logic [2:0]            sel_reason;
  logic [PC_WIDTH-1:0]   sel_pc;

  // Backend redirects may preempt at any time; fetch-side misses only start from IDLE.
  always_comb begin
    hi_req     = trapReq_i | branchReq_i | invalidateReq_i;
    miss_ok    = fetchMissReq_i && (fetchMissReason_i inside {R_ITLB, R_ICACHE, R_IBFULL});
    sel_reason = R_NONE;
    sel_pc     = pc_q;
    if (trapReq_i) begin
      sel_reason = R_TRAP;
      sel_pc     = trapVector_i;
    end else if (branchReq_i) begin
      sel_reason = R_BRANCH;
      sel_pc     = branchTarget_i;
    end else if (invalidateReq_i) begin
      sel_reason = R_INVAL;
      sel_pc     = invalidatePc_i;
    end else if (miss_ok) begin
      sel_reason = fetchMissReason_i;
      sel_pc     = fetchMissPc_i;
    end
  end

  always_comb begin
    done_match = 1'b0;
    case (reason_q)
      R_INVAL:  done_match = icacheInvalidateDone_i;
      R_ITLB:   done_match = itlbRefillDone_i;
      R_ICACHE: done_match = icacheRefillDone_i;
      R_IBFULL: done_match = !insnBufferFull_i;
      default:  done_match = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    reason_d  = reason_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == S_WAIT) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      if (cnt_q >= CNT_MAX - CNT_ONE) timeout_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (hi_req || miss_ok) begin
          state_d  = S_FLUSH;
          reason_d = sel_reason;
          pc_d     = sel_pc;
        end
      end
      S_FLUSH: begin
        if (hi_req) begin
          reason_d = sel_reason;
          pc_d     = sel_pc;
        end else if (reason_q == R_BRANCH || reason_q == R_TRAP) begin
          state_d = S_RESTART;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (hi_req) begin
          state_d  = S_FLUSH;
          reason_d = sel_reason;
          pc_d     = sel_pc;
        end else if (done_match) begin
          state_d = S_RESTART;
        end
      end
      S_RESTART: begin
        state_d = S_IDLE;
        if (hi_req) begin
          state_d  = S_FLUSH;
          reason_d = sel_reason;
          pc_d     = sel_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RESTART;
      reason_q  <= R_NONE;
      pc_q      <= INITIAL_PC;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reason_q  <= reason_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush_o               = (state_q == S_FLUSH);
  assign flushReason_o         = flush_o ? reason_q : R_NONE;
  assign redirectPc_o          = pc_q;
  assign restartValid_o        = (state_q == S_RESTART);
  assign fetchEnable_o         = (state_q == S_IDLE);
  assign busy_o                = (state_q != S_IDLE);
  assign itlbRefillReq_o       = (state_q == S_WAIT) && (reason_q == R_ITLB);
  assign icacheRefillReq_o     = (state_q == S_WAIT) && (reason_q == R_ICACHE);
  assign icacheInvalidateReq_o = (state_q == S_WAIT) && (reason_q == R_INVAL);
  assign timeout_o             = timeout_q;

endmodule
